// File: rtl/ram_port_arbiter_if.sv
// Signal bundle between the two client ports, the arbiter and the shared RAM.
// master = clients plus RAM instance side, slave = arbiter side.
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              rvalid0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              rvalid1;

  logic [DATA_W-1:0] rdata;
  logic              init_done;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_q;

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output ram_q,
    input  gnt0, rvalid0, gnt1, rvalid1,
    input  rdata, init_done,
    input  ram_we, ram_addr, ram_wdata
  );

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  ram_q,
    output gnt0, rvalid0, gnt1, rvalid1,
    output rdata, init_done,
    output ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between two requesters.
// Define MEM_CLEAR_EN to zero the whole RAM after every reset before accepting traffic.
module ram_port_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_port_arbiter_if.slave bus
);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              last_gnt_q;
  logic [ADDR_W-1:0] addr_hold_q;
  logic [DATA_W-1:0] wdata_hold_q;
  logic              rvalid0_q;
  logic              rvalid1_q;

  logic              gnt0;
  logic              gnt1;
  logic              ram_we_c;
  logic [ADDR_W-1:0] ram_addr_c;
  logic [DATA_W-1:0] ram_wdata_c;

`ifdef MEM_CLEAR_EN
  localparam state_t            RESET_STATE = CLEAR;
  localparam logic [ADDR_W-1:0] LAST_ADDR   = '1;

  logic [ADDR_W-1:0] sweep_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_q <= '0;
    end else if (state_q == CLEAR) begin
      sweep_q <= sweep_q + 1'b1;
    end
  end
`else
  localparam state_t RESET_STATE = RUN;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grants and the RAM bus are combinational so a request is served in its own cycle;
  // when nobody is granted the address and data hold their previous values.
  always_comb begin
    state_d     = state_q;
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    ram_we_c    = 1'b0;
    ram_addr_c  = addr_hold_q;
    ram_wdata_c = wdata_hold_q;
    case (state_q)
`ifdef MEM_CLEAR_EN
      CLEAR: begin
        ram_we_c    = 1'b1;
        ram_addr_c  = sweep_q;
        ram_wdata_c = '0;
        if (sweep_q == LAST_ADDR) begin
          state_d = RUN;
        end
      end
`endif
      RUN: begin
        if (bus.req0 && (!bus.req1 || last_gnt_q)) begin
          gnt0 = 1'b1;
        end else if (bus.req1) begin
          gnt1 = 1'b1;
        end
        if (gnt0) begin
          ram_we_c    = bus.we0;
          ram_addr_c  = bus.addr0;
          ram_wdata_c = bus.wdata0;
        end else if (gnt1) begin
          ram_we_c    = bus.we1;
          ram_addr_c  = bus.addr1;
          ram_wdata_c = bus.wdata1;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
    // Keep the RAM and the clients quiet while reset is asserted.
    if (!rst_n) begin
      gnt0        = 1'b0;
      gnt1        = 1'b0;
      ram_we_c    = 1'b0;
      ram_addr_c  = '0;
      ram_wdata_c = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q   <= 1'b1;
      addr_hold_q  <= '0;
      wdata_hold_q <= '0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
    end else begin
      addr_hold_q  <= ram_addr_c;
      wdata_hold_q <= ram_wdata_c;
      rvalid0_q    <= gnt0 && !bus.we0;
      rvalid1_q    <= gnt1 && !bus.we1;
      if (gnt0) begin
        last_gnt_q <= 1'b0;
      end else if (gnt1) begin
        last_gnt_q <= 1'b1;
      end
    end
  end

  assign bus.gnt0      = gnt0;
  assign bus.gnt1      = gnt1;
  assign bus.rvalid0   = rvalid0_q;
  assign bus.rvalid1   = rvalid1_q;
  assign bus.rdata     = bus.ram_q;
  assign bus.init_done = (state_q == RUN);
  assign bus.ram_we    = ram_we_c;
  assign bus.ram_addr  = ram_addr_c;
  assign bus.ram_wdata = ram_wdata_c;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter with a behavioural 64x8 RAM.
// Build with MEM_CLEAR_EN defined to exercise the post-reset clear sweep.
module tb_ram_port_arbiter;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Synchronous RAM with a registered read address: q follows one cycle after the address edge.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] ram_addr_r;

  always @(posedge clk) begin
    if (bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
    end
    ram_addr_r <= bus.ram_addr;
  end

  assign bus.ram_q = mem[ram_addr_r];

`ifdef MEM_CLEAR_EN
  localparam logic EXP_INIT_RESET = 1'b0;
`else
  localparam logic EXP_INIT_RESET = 1'b1;
`endif

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic w0, input logic [ADDR_W-1:0] a0,
                               input logic [DATA_W-1:0] d0, input logic r1, input logic w1,
                               input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
    @(posedge clk);
    #1;
    bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
    bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
  endtask

  task automatic waitInitDone(output int cycles, output int weCycles, output logic done);
    cycles = 0;
    weCycles = 0;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (bus.init_done) begin
        done = 1'b1;
      end else begin
        cycles++;
        if (bus.ram_we) weCycles++;
        @(negedge clk);
      end
    end
  endtask

  initial begin
    int   cycles;
    int   weCycles;
    logic done;

    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    rst_n = 1'b0;
    #12;
    checkOutput("reset_gnt0", bus.gnt0, 0);
    checkOutput("reset_gnt1", bus.gnt1, 0);
    checkOutput("reset_rvalid0", bus.rvalid0, 0);
    checkOutput("reset_rvalid1", bus.rvalid1, 0);
    checkOutput("reset_ram_we", bus.ram_we, 0);
    checkOutput("reset_ram_addr", bus.ram_addr, 0);
    checkOutput("reset_ram_wdata", bus.ram_wdata, 0);
    checkOutput("reset_init_done", bus.init_done, EXP_INIT_RESET);
    bus.req0 = 1'b0;

`ifdef MEM_CLEAR_EN
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("sweep_first_addr", bus.ram_addr, 0);
    waitInitDone(cycles, weCycles, done);
    checkOutput("init_done_seen", done, 1);
    checkOutput("clear_we_cycles", weCycles, 64);
    checkOutput("init_done_delay", cycles, 64);
    applyStimulus(1, 0, 6'd0, 8'h00, 0, 0, 6'd0, 8'h00);
    @(negedge clk);
    checkOutput("clr_rd0_gnt0", bus.gnt0, 1);
    applyStimulus(1, 0, 6'd31, 8'h00, 0, 0, 6'd0, 8'h00);
    @(negedge clk);
    checkOutput("clr_rd0_rvalid", bus.rvalid0, 1);
    checkOutput("clr_rd0_rdata", bus.rdata, 8'h00);
    applyStimulus(1, 0, 6'd63, 8'h00, 0, 0, 6'd0, 8'h00);
    @(negedge clk);
    checkOutput("clr_rd31_rvalid", bus.rvalid0, 1);
    checkOutput("clr_rd31_rdata", bus.rdata, 8'h00);
    applyStimulus(0, 0, 6'd0, 8'h00, 0, 0, 6'd0, 8'h00);
    @(negedge clk);
    checkOutput("clr_rd63_rvalid", bus.rvalid0, 1);
    checkOutput("clr_rd63_rdata", bus.rdata, 8'h00);
`else
    @(negedge clk);
    rst_n = 1'b1;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 6'd5;
    #1;
    checkOutput("first_cycle_gnt1", bus.gnt1, 1);
    checkOutput("first_cycle_gnt0", bus.gnt0, 0);
    checkOutput("first_cycle_init", bus.init_done, 1);
    checkOutput("first_cycle_addr", bus.ram_addr, 6'd5);
    applyStimulus(0, 0, 6'd0, 8'h00, 0, 0, 6'd0, 8'h00);
    @(negedge clk);
    checkOutput("first_read_rvalid1", bus.rvalid1, 1);
    checkOutput("first_read_init", bus.init_done, 1);
`endif

    // Port 0 write then read back the same address.
    applyStimulus(1, 1, 6'h10, 8'hA5, 0, 0, 6'd0, 8'h00);
    @(negedge clk);
    checkOutput("wr10_gnt0", bus.gnt0, 1);
    checkOutput("wr10_gnt1", bus.gnt1, 0);
    checkOutput("wr10_ram_we", bus.ram_we, 1);
    checkOutput("wr10_ram_addr", bus.ram_addr, 6'h10);
    checkOutput("wr10_ram_wdata", bus.ram_wdata, 8'hA5);
    applyStimulus(1, 0, 6'h10, 8'h00, 0, 0, 6'd0, 8'h00);
    @(negedge clk);
    checkOutput("rd10_gnt0", bus.gnt0, 1);
    checkOutput("rd10_ram_we", bus.ram_we, 0);
    checkOutput("wr10_no_rvalid", bus.rvalid0, 0);
    applyStimulus(0, 0, 6'd0, 8'h00, 0, 0, 6'd0, 8'h00);
    @(negedge clk);
    checkOutput("rd10_rvalid0", bus.rvalid0, 1);
    checkOutput("rd10_rvalid1", bus.rvalid1, 0);
    checkOutput("rd10_rdata", bus.rdata, 8'hA5);
    checkOutput("idle_ram_we", bus.ram_we, 0);
    checkOutput("idle_addr_hold", bus.ram_addr, 6'h10);
    applyStimulus(0, 0, 6'd0, 8'h00, 0, 0, 6'd0, 8'h00);
    @(negedge clk);
    checkOutput("rd10_rvalid0_once", bus.rvalid0, 0);

    // Port 1 write, port 0 reads the same location.
    applyStimulus(0, 0, 6'd0, 8'h00, 1, 1, 6'h3F, 8'h3C);
    @(negedge clk);
    checkOutput("wr3f_gnt1", bus.gnt1, 1);
    checkOutput("wr3f_gnt0", bus.gnt0, 0);
    checkOutput("wr3f_ram_addr", bus.ram_addr, 6'h3F);
    checkOutput("wr3f_ram_wdata", bus.ram_wdata, 8'h3C);
    applyStimulus(1, 0, 6'h3F, 8'h00, 0, 0, 6'd0, 8'h00);
    @(negedge clk);
    checkOutput("rd3f_gnt0", bus.gnt0, 1);
    checkOutput("wr3f_no_rvalid1", bus.rvalid1, 0);
    applyStimulus(0, 0, 6'd0, 8'h00, 1, 0, 6'h10, 8'h00);
    @(negedge clk);
    checkOutput("rd3f_rvalid0", bus.rvalid0, 1);
    checkOutput("rd3f_rdata", bus.rdata, 8'h3C);
    checkOutput("rd10p1_gnt1", bus.gnt1, 1);

    // Both ports reading continuously: port 0 wins first since port 1 was granted last.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, 6'h3F, 8'h00, 1, 0, 6'h10, 8'h00);
      @(negedge clk);
      checkOutput($sformatf("rr%0d_gnt0", i), bus.gnt0, (i % 2 == 0));
      checkOutput($sformatf("rr%0d_gnt1", i), bus.gnt1, (i % 2 == 1));
      checkOutput($sformatf("rr%0d_rvalid0", i), bus.rvalid0, (i % 2 == 1));
      checkOutput($sformatf("rr%0d_rvalid1", i), bus.rvalid1, (i % 2 == 0));
      checkOutput($sformatf("rr%0d_rdata", i), bus.rdata, (i % 2 == 1) ? 8'h3C : 8'hA5);
    end
    applyStimulus(0, 0, 6'd0, 8'h00, 0, 0, 6'd0, 8'h00);
    @(negedge clk);
    checkOutput("rr_tail_rvalid1", bus.rvalid1, 1);
    checkOutput("rr_tail_rvalid0", bus.rvalid0, 0);
    checkOutput("rr_tail_rdata", bus.rdata, 8'hA5);

    // Reset asserted while a read result is being returned.
    applyStimulus(1, 0, 6'h10, 8'h00, 0, 0, 6'd0, 8'h00);
    @(negedge clk);
    checkOutput("mid_rd_gnt0", bus.gnt0, 1);
    applyStimulus(0, 0, 6'd0, 8'h00, 0, 0, 6'd0, 8'h00);
    checkOutput("mid_rvalid_before", bus.rvalid0, 1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rvalid_dropped", bus.rvalid0, 0);
    checkOutput("mid_init_done", bus.init_done, EXP_INIT_RESET);
    checkOutput("mid_ram_addr", bus.ram_addr, 0);
    checkOutput("mid_ram_we", bus.ram_we, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
`ifdef MEM_CLEAR_EN
    checkOutput("resweep_addr0", bus.ram_addr, 0);
    checkOutput("resweep_we", bus.ram_we, 1);
    @(negedge clk);
    checkOutput("resweep_addr1", bus.ram_addr, 1);
    waitInitDone(cycles, weCycles, done);
    checkOutput("resweep_init_done", done, 1);
`else
    checkOutput("rerun_init_done", bus.init_done, 1);
`endif

    // Pointer is back at its reset value, so a tie goes to port 0.
    applyStimulus(1, 0, 6'h3F, 8'h00, 1, 0, 6'h10, 8'h00);
    @(negedge clk);
    checkOutput("post_reset_tie_gnt0", bus.gnt0, 1);
    checkOutput("post_reset_tie_gnt1", bus.gnt1, 0);
    applyStimulus(0, 0, 6'd0, 8'h00, 0, 0, 6'd0, 8'h00);
    @(negedge clk);
    checkOutput("post_reset_rvalid0", bus.rvalid0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one 64x8 single-port synchronous RAM between two requesters (port 0, port 1) with round-robin arbitration.
- The RAM has a registered read address: q is valid the cycle after the address edge.
- The block sits between the two client engines and the RAM instance. It drives the RAM's we/addr/data and returns read data with a valid strobe to the winning port.
- Optionally sweeps the RAM to zero after reset before accepting traffic.

Parameters:
- ADDR_W, 6, RAM address width (depth = 2**ADDR_W).
- DATA_W, 8, RAM data width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req0  input  1  port 0 access request, held until granted
- we0  input  1  port 0 write (1) / read (0)
- addr0  input  ADDR_W  port 0 address
- wdata0  input  DATA_W  port 0 write data
- gnt0  output  1  port 0 granted this cycle (combinational)
- rvalid0  output  1  port 0 read data valid (registered)
- req1, we1, addr1, wdata1, gnt1, rvalid1: same as port 0, for port 1
- rdata  output  DATA_W  read data, shared; qualify with rvalid0/rvalid1
- init_done  output  1  high once the block accepts requests
- ram_we  output  1  to RAM we
- ram_addr  output  ADDR_W  to RAM addr
- ram_wdata  output  DATA_W  to RAM data
- ram_q  input  DATA_W  from RAM q

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. All state clears immediately on rst_n low, regardless of clk.
- Reset values: gnt0=gnt1=0, rvalid0=rvalid1=0, init_done=0 (=1 when MEM_CLEAR_EN is undefined), ram_we=0, ram_addr=0, ram_wdata=0, last-grant pointer=1 (so port 0 wins the first tie).
- FSM states: CLEAR -> RUN. Reset enters CLEAR when MEM_CLEAR_EN is defined, otherwise RUN. RUN is terminal until the next reset.
- CLEAR state:
  - ram_we=1, ram_wdata=0, ram_addr = sweep counter, counting 0..2**ADDR_W-1, one address per cycle.
  - On the cycle the counter reaches the last address, the next state is RUN and init_done rises the following cycle.
  - No grants are issued in CLEAR; requests are held off (gnt=0).
- RUN state, arbitration (combinational, same cycle as req):
  - Only req0 high: gnt0=1.
  - Only req1 high: gnt1=1.
  - Both high: grant the port not granted most recently.
  - Neither high: no grant, ram_we=0, ram_addr holds its last value.
  - At most one gnt is high in any cycle.
- Transfer: a transfer completes on the clock edge where reqN & gntN. ram_we/ram_addr/ram_wdata are muxed combinationally from the granted port. The pointer updates to the granted port on that edge.
- Read latency: for a granted read on edge T, rvalidN=1 for exactly the cycle after T and rdata=ram_q in that cycle. Back-to-back reads give one result per cycle.
- Writes produce no rvalid. A write then a read to the same address on the next grant returns the new data.
- Read-after-write on the same edge cannot occur (one access per cycle).
- rdata is a pass-through of ram_q; its value outside an rvalid cycle is don't-care.
- Reset mid-operation:
  - Any in-flight rvalid is dropped.
  - Any CLEAR sweep restarts from address 0.
  - The RAM contents are not guaranteed without MEM_CLEAR_EN.

Optional Feature:
- Macro: MEM_CLEAR_EN.
- Defined: after every reset the block spends 2**ADDR_W cycles (64 by default) in CLEAR, zeroing the RAM. init_done rises on cycle 2**ADDR_W+1 after rst_n release.
- Undefined: the CLEAR state and sweep counter are not built, init_done=1 from reset, and the RAM contents after reset are undefined.

Test Plan:
- MEM_CLEAR_EN, release rst_n, wait for init_done, read addresses 0, 31 and 63 via port 0 -> ram_we high for exactly 64 cycles, then all three reads return 8'h00.
- Port 0 writes 8'hA5 to addr 6'h10, then reads 6'h10 -> gnt0 is high in both cycles, rvalid0 is high exactly one cycle after the read grant, rdata=8'hA5, rvalid1 stays 0.
- req0 and req1 held high continuously for 6 cycles, both reading -> gnt sequence 0,1,0,1,0,1 and rvalid sequence alternates the same way, delayed by one cycle.
- Port 1 writes 8'h3C to addr 6'h3F while port 0 is idle, then port 0 reads 6'h3F -> rdata=8'h3C with rvalid0.
- Assert rst_n low mid-stream, 1 cycle after a granted read -> rvalid0 goes 0 immediately (asynchronously), init_done=0 (MEM_CLEAR_EN), and the sweep restarts at addr 0.
- Without MEM_CLEAR_EN, req1 read in the first cycle after reset release -> gnt1 is high that cycle and init_done=1 throughout.
